lzd_norm_pipe: RTL

- Parametrised, pipelined leading-zero detector and normaliser for the AWGN datapath.
- Accepts a WIDTH-bit unsigned operand under a valid/ready handshake.
- Returns the leading-zero count, an all-zero flag and the operand left-shifted so that its MSB is set.
- Serves the log/sqrt floating-point stages of the Box-Muller core. It replaces the fixed 48-bit combinational detector and adds throughput of one result per cycle with backpressure.

---
 rtl/lzd_norm_pipe.sv | 102 ++++++++++
 1 files changed

// File: rtl/lzd_norm_pipe.sv
// Two-stage pipelined leading-zero detector and normaliser with valid/ready flow control.
// Optional trailing-zero mode is enabled by defining LZD_TZ_EN (adds the tz_mode port).
module lzd_norm_pipe #(
    parameter int unsigned WIDTH  = 48,
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned ENABLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef LZD_TZ_EN
    input  logic             tz_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm
);

    logic             in_tz;
    logic             s2_advance;
    logic [CNT_W-1:0] enc_count;
    logic             enc_zero;
    logic [WIDTH-1:0] norm_next;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [CNT_W-1:0] s1_count;
    logic             s1_zero;
    logic             s1_tz;

`ifdef LZD_TZ_EN
    assign in_tz = tz_mode;
`else
    assign in_tz = 1'b0;
`endif

    // S2 can take new data when empty or being drained; S1 likewise when S2 moves.
    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;

    // Priority encoder: the last matching iteration wins, giving the first 1 from the chosen end.
    always_comb begin
        enc_zero  = (in_data == '0);
        enc_count = CNT_W'(WIDTH);
        if (in_tz) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (in_data[i]) enc_count = CNT_W'(i);
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (in_data[i]) enc_count = CNT_W'(int'(WIDTH) - 1 - i);
            end
        end
        if (ENABLE == 0) begin
            enc_count = CNT_W'(WIDTH);
            enc_zero  = 1'b1;
        end
    end

    // A shift by WIDTH naturally yields zero, so all-zero operands need no special case.
    always_comb begin
        norm_next = s1_tz ? (s1_data >> s1_count) : (s1_data << s1_count);
        if (ENABLE == 0) norm_next = s1_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_count  <= '0;
            s1_zero   <= 1'b0;
            s1_tz     <= 1'b0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_zero  <= 1'b0;
            out_norm  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data  <= in_data;
                    s1_count <= enc_count;
                    s1_zero  <= enc_zero;
                    s1_tz    <= in_tz;
                end
            end
            if (s2_advance) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_count <= s1_count;
                    out_zero  <= s1_zero;
                    out_norm  <= norm_next;
                end
            end
        end
    end

endmodule
